// File: rtl/des_key_sched_dec.sv
// DES key schedule that streams the 16 round subkeys in decryption order (K16 .. K1)
// over a valid/ready handshake, one subkey per accepted transfer.
module des_key_sched_dec (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key_in,
    input  logic        key_valid,
    output logic        key_ready,
    output logic [47:0] sk_out,
    output logic [3:0]  sk_round,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic        busy
);

    // Entries are DES bit numbers (1 = MSB); element [N-1] is the first table entry.
    localparam logic [55:0][6:0] PC1 = {
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd58, 7'd50,
        7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35,
        7'd27, 7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7,  7'd62, 7'd54,
        7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37,
        7'd29, 7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    localparam logic [47:0][5:0] PC2 = {
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,
        6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,
        6'd27, 6'd20, 6'd13, 6'd2,  6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
        6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state;
    logic [27:0] c_reg;
    logic [27:0] d_reg;
    logic [3:0]  round;
    logic        one_step;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        logic [6:0]  t;
        o = '0;
        for (logic [5:0] i = 6'd0; i < 56; i++) begin
            t = 7'd64 - PC1[i];
            o[i] = k[t[5:0]];
        end
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (logic [5:0] i = 6'd0; i < 48; i++)
            o[i] = cd[6'd56 - PC2[i]];
        return o;
    endfunction

    assign key_ready = (state == IDLE);
    assign sk_valid  = (state == EMIT);
    assign busy      = (state == EMIT);
    assign sk_round  = round;
    assign sk_out    = pc2({c_reg, d_reg});

    // Leaving K(r+1) undoes its left shift; s=1 for K16, K9 and K2 (r = 15, 8, 1).
    assign one_step = (round == 4'd15) || (round == 4'd8) || (round == 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            c_reg <= '0;
            d_reg <= '0;
            round <= '0;
        end else begin
            case (state)
                IDLE: if (key_valid) begin
                    {c_reg, d_reg} <= pc1(key_in);
                    round          <= 4'd15;
                    state          <= EMIT;
                end
                EMIT: if (sk_ready) begin
                    if (round == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        if (one_step) begin
                            c_reg <= {c_reg[0], c_reg[27:1]};
                            d_reg <= {d_reg[0], d_reg[27:1]};
                        end else begin
                            c_reg <= {c_reg[1:0], c_reg[27:2]};
                            d_reg <= {d_reg[1:0], d_reg[27:2]};
                        end
                        round <= round - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_sched_dec.sv
// Bench for des_key_sched_dec: known-answer table, stall/ignore/reset sequences and
// random keys checked against a forward-order key schedule model through a scoreboard.
module tb_des_key_sched_dec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] key_in = '0;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [47:0] sk_out;
    logic [3:0]  sk_round;
    logic        sk_valid;
    logic        sk_ready = 1'b0;
    logic        busy;

    des_key_sched_dec dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
        .key_ready(key_ready), .sk_out(sk_out), .sk_round(sk_round),
        .sk_valid(sk_valid), .sk_ready(sk_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    localparam int PC1_T[56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_T[48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4,
        26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFTS[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef logic [15:0][47:0] ks_t;
    typedef struct { logic [47:0] sk; logic [3:0] rnd; } exp_t;
    typedef struct { logic [63:0] key; logic [47:0] k16; logic [47:0] k1; } vec_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Forward schedule: ks[i] holds K(i+1), built with left rotations.
    function automatic ks_t model(input logic [63:0] k);
        logic [27:0] c, d;
        logic [55:0] cd;
        ks_t         ks;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = k[64-PC1_T[i]];
            d[27-i] = k[64-PC1_T[28+i]];
        end
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHIFTS[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) ks[r][47-j] = cd[56-PC2_T[j]];
        end
        return ks;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_key(input logic [63:0] k);
        ks_t ks;
        exp_t e;
        ks = model(k);
        for (int r = 15; r >= 0; r--) begin
            e.sk  = ks[r];
            e.rnd = 4'(r);
            sb.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [63:0] drive_k, input logic [63:0] model_k);
        int t;
        t = 0;
        while (!key_ready && t < 100) begin
            step();
            t++;
        end
        check("key_ready_wait", key_ready, 1);
        key_in    = drive_k;
        key_valid = 1'b1;
        push_key(model_k);
        step();
        key_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int t;
        t = 0;
        while (busy && t < max_cyc) begin
            step();
            t++;
        end
        check("drain_done", busy, 0);
    endtask

    // Scoreboard: every handshake that the next rising edge will take is compared here.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && sk_valid && sk_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_extra: got subkey %h round %0d, expected none", sk_out, sk_round);
            end else begin
                e = sb.pop_front();
                check("sb_subkey", sk_out, e.sk);
                check("sb_round", sk_round, e.rnd);
            end
        end
    end

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

    initial begin
        vec_t        vecs[4];
        int          cnt, hs, t;
        logic        pend_idle;
        logic [63:0] rk, pmask;
        ks_t         ks;

        vecs[0] = '{KEY_A,                 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
        vecs[1] = '{64'h12355678_9ABDDEF0, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
        vecs[2] = '{64'h0,                 48'h0,            48'h0};
        vecs[3] = '{64'hFFFFFFFF_FFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF};

        // Asynchronous reset state, checked before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst_key_ready", key_ready, 1);
        check("rst_sk_valid", sk_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sk_round", sk_round, 0);
        check("rst_sk_out", sk_out, 0);
        #20 rst_n = 1'b1;
        step();

        // Known-answer vectors at full rate.
        sk_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            load_key(vecs[v].key, vecs[v].key);
            if (v == 0) begin
                check("c0", dut.c_reg, 64'hF0CCAAF);
                check("d0", dut.d_reg, 64'h556678F);
            end
            cnt = 0;
            while (sk_valid && cnt < 20) begin
                if (cnt == 0) begin
                    check("first_subkey", sk_out, vecs[v].k16);
                    check("first_round", sk_round, 15);
                end
                if (cnt == 15) begin
                    check("last_subkey", sk_out, vecs[v].k1);
                    check("last_round", sk_round, 0);
                end
                cnt++;
                step();
            end
            check("valid_cycles", cnt, 16);
            check("idle_key_ready", key_ready, 1);
        end

        // Consumer stall on K16.
        sk_ready = 1'b0;
        load_key(KEY_A, KEY_A);
        repeat (5) begin
            check("stall_subkey", sk_out, 48'hCB3D8B0E17F5);
            check("stall_round", sk_round, 15);
            check("stall_valid", sk_valid, 1);
            step();
        end
        sk_ready = 1'b1;
        drain(40);

        // A second key offered mid-sequence must be ignored.
        load_key(KEY_A, KEY_A);
        repeat (3) step();
        key_in    = 64'h0E329232EA6D0D73;
        key_valid = 1'b1;
        repeat (4) begin
            check("emit_key_ready", key_ready, 0);
            step();
        end
        key_valid = 1'b0;
        drain(40);

        // Asynchronous reset after the 7th handshake, then key accepted on first edge.
        load_key(KEY_A, KEY_A);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_sk_valid", sk_valid, 0);
        check("abort_key_ready", key_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_sk_round", sk_round, 0);
        check("abort_sk_out", sk_out, 0);
        sb.delete();
        rk = {$urandom, $urandom};
        ks = model(rk);
        key_in    = rk;
        key_valid = 1'b1;
        push_key(rk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        key_valid = 1'b0;
        check("restart_valid", sk_valid, 1);
        check("restart_round", sk_round, 15);
        check("restart_subkey", sk_out, ks[15]);
        drain(40);

        // Random keys, some with flipped parity bits, random back-pressure.
        for (int k = 0; k < 6; k++) begin
            rk    = {$urandom, $urandom};
            pmask = (k % 2 == 1) ? ({$urandom, $urandom} & 64'h0101010101010101) : 64'h0;
            load_key(rk ^ pmask, rk);
            hs = 0;
            pend_idle = 1'b0;
            t = 0;
            while (t < 200) begin
                sk_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (pend_idle) begin
                    check("busy_after_k1", busy, 0);
                    break;
                end
                if (sk_valid && sk_ready) begin
                    hs++;
                    if (sk_round == 4'd0) pend_idle = 1'b1;
                end
                @(posedge clk);
                #1;
                t++;
            end
            check("handshakes_per_key", hs, 16);
            step();
        end

        check("sb_left", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
